// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock through one ripple slice
// with a registered carry, behind a start/done handshake.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // state | meaning
    // IDLE  | waiting for start, last result held
    // RUN   | one digit processed per clock
    // DONE  | result valid, done pulse; start accepted back-to-back
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_reg, b_reg, s_reg, s_shift;
    logic             carry, cout_reg, ovf_reg;
    logic             accept, last, c_msb;
    logic [DIGIT:0]   dsum;

    assign accept = start && (state != RUN);
    assign last   = (count == LAST);
    assign dsum   = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the slice MSB recovered from its sum bit and operand bits.
    assign c_msb  = dsum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];

    if (DIGIT == WIDTH) begin : g_single
        assign s_shift = dsum[DIGIT-1:0];
    end else begin : g_multi
        assign s_shift = {dsum[DIGIT-1:0], s_reg[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B ^ {WIDTH{sub}};
            carry <= Cin ^ sub;
            count <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> DIGIT;
            b_reg <= b_reg >> DIGIT;
            s_reg <= s_shift;
            carry <= dsum[DIGIT];
            if (last) begin
                count    <= '0;
                cout_reg <= dsum[DIGIT];
                ovf_reg  <= c_msb ^ dsum[DIGIT];
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign S    = s_reg;
    assign Cout = cout_reg;
    assign Ovf  = ovf_reg;
endmodule
